writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 24 ++
 rtl/writeback_load_align.sv | 43 ++++
 rtl/writeback.sv | 117 +++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : writeback_pkg
// Purpose : Load funct3 encodings and writeback FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package writeback_pkg;

  localparam logic [2:0] LB      = 3'b000;
  localparam logic [2:0] LH      = 3'b001;
  localparam logic [2:0] LW      = 3'b010;
  localparam logic [2:0] LD      = 3'b011;
  localparam logic [2:0] LBU     = 3'b100;
  localparam logic [2:0] LHU     = 3'b101;
  localparam logic [2:0] LWU     = 3'b110;
  localparam logic [2:0] LILLEGAL = 3'b111;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/writeback_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Purpose : Selects and sign/zero-extends load data from an aligned doubleword.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
  import writeback_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic [BUS_DATA_WIDTH-1:0] data_i,
  input  logic [2:0]                funct3_i,
  input  logic [2:0]                addr_low_i,
  output logic [BUS_DATA_WIDTH-1:0] data_o,
  output logic                      illegal_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  // Low address bits below the access size are dropped, aligning down.
  always_comb begin
    w_byte    = data_i[{addr_low_i, 3'b000} +: 8];
    w_half    = data_i[{addr_low_i[2:1], 4'b0000} +: 16];
    w_word    = data_i[{addr_low_i[2], 5'b00000} +: 32];
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      LB:      data_o = {{(BUS_DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LH:      data_o = {{(BUS_DATA_WIDTH-16){w_half[15]}}, w_half};
      LW:      data_o = {{(BUS_DATA_WIDTH-32){w_word[31]}}, w_word};
      LD:      data_o = data_i;
      LBU:     data_o = {{(BUS_DATA_WIDTH-8){1'b0}}, w_byte};
      LHU:     data_o = {{(BUS_DATA_WIDTH-16){1'b0}}, w_half};
      LWU:     data_o = {{(BUS_DATA_WIDTH-32){1'b0}}, w_word};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module  : writeback
// Purpose : Pipeline writeback stage; waits for load responses, retires ops.
// Revision: 1.0 - initial release
// ============================================================================
module writeback
  import writeback_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_en,
  input  logic                      inRegWrite,
  input  logic                      inMemOrReg,
  input  logic [4:0]                inDestReg,
  input  logic [BUS_DATA_WIDTH-1:0] inAluResult,
  input  logic [2:0]                inLoadFunct3,
  input  logic [2:0]                inAddrLow,
  input  logic                      memRespValid,
  input  logic [BUS_DATA_WIDTH-1:0] memRespData,
  output logic                      outRegWrite,
  output logic [4:0]                outDestReg,
  output logic [BUS_DATA_WIDTH-1:0] outMemOrRegData,
  output logic                      outStall,
  output logic                      outIllegal,
  output logic [63:0]               outRetired
);

  wb_state_e                 state_q;
  logic [4:0]                pend_dest_q;
  logic [2:0]                pend_funct3_q;
  logic [2:0]                pend_addr_q;
  logic                      regwrite_q;
  logic [4:0]                dest_q;
  logic [BUS_DATA_WIDTH-1:0] data_q;
  logic                      illegal_q;
  logic [63:0]               retired_q;

  logic                      w_waiting;
  logic [4:0]                w_dest;
  logic [2:0]                w_funct3;
  logic [2:0]                w_addr;
  logic                      w_load_done;
  logic [BUS_DATA_WIDTH-1:0] w_align_data;
  logic                      w_align_illegal;

  // While waiting, the captured fields steer extraction instead of live inputs.
  assign w_waiting   = (state_q == WAIT_MEM);
  assign w_dest      = w_waiting ? pend_dest_q   : inDestReg;
  assign w_funct3    = w_waiting ? pend_funct3_q : inLoadFunct3;
  assign w_addr      = w_waiting ? pend_addr_q   : inAddrLow;
  assign w_load_done = memRespValid &&
                       (w_waiting || (wb_en && inRegWrite && inMemOrReg));

  load_align #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH)
  ) u_load_align (
    .data_i    (memRespData),
    .funct3_i  (w_funct3),
    .addr_low_i(w_addr),
    .data_o    (w_align_data),
    .illegal_o (w_align_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_dest_q   <= '0;
      pend_funct3_q <= '0;
      pend_addr_q   <= '0;
      regwrite_q    <= 1'b0;
      dest_q        <= '0;
      data_q        <= '0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
    end else begin
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (w_load_done) begin
        state_q   <= IDLE;
        retired_q <= retired_q + 64'd1;
        if (w_align_illegal) begin
          illegal_q <= 1'b1;
        end else if (w_dest != 5'd0) begin
          regwrite_q <= 1'b1;
          dest_q     <= w_dest;
          data_q     <= w_align_data;
        end
      end else if (!w_waiting && wb_en) begin
        if (inRegWrite && inMemOrReg) begin
          state_q       <= WAIT_MEM;
          pend_dest_q   <= inDestReg;
          pend_funct3_q <= inLoadFunct3;
          pend_addr_q   <= inAddrLow;
        end else begin
          retired_q <= retired_q + 64'd1;
          if (inRegWrite && (inDestReg != 5'd0)) begin
            regwrite_q <= 1'b1;
            dest_q     <= inDestReg;
            data_q     <= inAluResult;
          end
        end
      end
    end
  end

  assign outRegWrite     = regwrite_q;
  assign outDestReg      = dest_q;
  assign outMemOrRegData = data_q;
  assign outStall        = w_waiting;
  assign outIllegal      = illegal_q;
  assign outRetired      = retired_q;

endmodule
`default_nettype wire
